// File: rtl/sca_blk_pkg.sv
// SCA block-allocation sequencer.
// Shared widths, depths and one-hot state codes.
package sca_blk_pkg;

  localparam int ADR_W        = 4;
  localparam int FIFO_DEPTH   = 16;
  localparam int CNT_W        = 5;
  localparam int INIT_CYC_DEF = 18;
  localparam int ST_W         = 6;

  typedef logic [ADR_W-1:0] adr_t;

  typedef enum int {
    B_INIT = 0,
    B_IDLE = 1,
    B_SEL  = 2,
    B_CHK  = 3,
    B_REL  = 4,
    B_HOLD = 5
  } st_bit_e;

  localparam logic [ST_W-1:0] ST_INIT = 6'b000001;
  localparam logic [ST_W-1:0] ST_IDLE = 6'b000010;
  localparam logic [ST_W-1:0] ST_SEL  = 6'b000100;
  localparam logic [ST_W-1:0] ST_CHK  = 6'b001000;
  localparam logic [ST_W-1:0] ST_REL  = 6'b010000;
  localparam logic [ST_W-1:0] ST_HOLD = 6'b100000;

endpackage

// File: rtl/sca_blk_if.sv
// SCA sequencer bundle: requester handshake plus
// the block-allocation manager select/write bus.
interface sca_blk_if;
  import sca_blk_pkg::*;

  logic             ALLOC_REQ;
  logic             REL_REQ;
  logic             ALLOC_ACK;
  logic             ALLOC_FAIL;
  adr_t             ALLOC_ADR;
  logic             REL_ACK;
  logic             REL_ERR;
  adr_t             REL_ADR;
  logic             BUSY;
  logic [CNT_W-1:0] OCC_CNT;
  logic             NBSEL;
  logic             WRENA;
  logic             SELA;
  adr_t             BADR;
  adr_t             RDADR;
  adr_t             NADR;
  logic             SCAFULL;

  modport master (
    input  ALLOC_REQ, REL_REQ,
    input  NADR, SCAFULL,
    output ALLOC_ACK, ALLOC_FAIL, ALLOC_ADR,
    output REL_ACK, REL_ERR, REL_ADR,
    output BUSY, OCC_CNT,
    output NBSEL, WRENA, SELA, BADR, RDADR
  );

  modport slave (
    output ALLOC_REQ, REL_REQ,
    output NADR, SCAFULL,
    input  ALLOC_ACK, ALLOC_FAIL, ALLOC_ADR,
    input  REL_ACK, REL_ERR, REL_ADR,
    input  BUSY, OCC_CNT,
    input  NBSEL, WRENA, SELA, BADR, RDADR
  );

endinterface

// File: rtl/sca_adr_fifo.sv
// In-order occupancy FIFO of granted block addresses.
// Pointers carry an extra wrap bit so count spans 0..16.
module sca_adr_fifo import sca_blk_pkg::*; #(
  parameter bit TMR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  adr_t             din,
  output adr_t             head,
  output logic [CNT_W-1:0] count
);

  localparam int NR = TMR ? 3 : 1;
  localparam int IB = TMR ? 1 : 0;
  localparam int IC = TMR ? 2 : 0;

  logic [CNT_W-1:0] wp_q [NR];
  logic [CNT_W-1:0] rp_q [NR];
  logic [CNT_W-1:0] wp;
  logic [CNT_W-1:0] rp;
  adr_t             mem  [FIFO_DEPTH];

  // majority vote collapses to copy 0 without TMR
  assign wp = (wp_q[0] & wp_q[IB]) |
              (wp_q[0] & wp_q[IC]) |
              (wp_q[IB] & wp_q[IC]);
  assign rp = (rp_q[0] & rp_q[IB]) |
              (rp_q[0] & rp_q[IC]) |
              (rp_q[IB] & rp_q[IC]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        wp_q[i] <= push ? wp + 1'b1 : wp;
        rp_q[i] <= pop  ? rp + 1'b1 : rp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[ADR_W-1:0]] <= din;
  end

  assign head  = mem[rp[ADR_W-1:0]];
  assign count = wp - rp;

endmodule

// File: rtl/sca_blk_seq.sv
// Allocation/release sequencer for the SCA free-block manager.
// Grants blocks via NBSEL/WRENA cycles and releases them oldest-first.
module sca_blk_seq import sca_blk_pkg::*; #(
  parameter bit   TMR       = 1'b0,
  parameter int   INIT_CYC  = INIT_CYC_DEF,
  parameter adr_t START_ADR = 4'h0
) (
  input  logic      CLK,
  input  logic      RST_N,
  sca_blk_if.master bus
);

  localparam int NR = TMR ? 3 : 1;
  localparam int IB = TMR ? 1 : 0;
  localparam int IC = TMR ? 2 : 0;

  logic [ST_W-1:0]  st_q [NR];
  logic [ST_W-1:0]  st;
  logic [ST_W-1:0]  st_d;
  adr_t             rd_q [NR];
  adr_t             rd;
  adr_t             aadr_q;
  adr_t             radr_q;
  logic [7:0]       icnt;
  adr_t             head;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             in_chk;
  logic             in_rel;
  logic             a_ok;
  logic             r_ok;

  assign st = (st_q[0] & st_q[IB]) |
              (st_q[0] & st_q[IC]) |
              (st_q[IB] & st_q[IC]);
  assign rd = (rd_q[0] & rd_q[IB]) |
              (rd_q[0] & rd_q[IC]) |
              (rd_q[IB] & rd_q[IC]);

  // release wins arbitration so space is freed first
  always_comb begin
    st_d = st;
    unique case (1'b1)
      st[B_INIT]: begin
        if (icnt == 8'(INIT_CYC - 1)) st_d = ST_IDLE;
      end
      st[B_IDLE]: begin
        if (bus.REL_REQ)        st_d = ST_REL;
        else if (bus.ALLOC_REQ) st_d = ST_SEL;
      end
      st[B_SEL]:  st_d = ST_CHK;
      st[B_CHK]:  st_d = ST_HOLD;
      st[B_REL]:  st_d = ST_HOLD;
      st[B_HOLD]: st_d = ST_IDLE;
      default:    st_d = ST_INIT;
    endcase
  end

  assign full   = cnt == CNT_W'(FIFO_DEPTH);
  assign empty  = cnt == '0;
  assign in_chk = st[B_CHK];
  assign in_rel = st[B_REL];
  assign a_ok   = in_chk && !bus.SCAFULL && !full;
  assign r_ok   = in_rel && !empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NR; i++) begin
        st_q[i] <= ST_INIT;
        rd_q[i] <= START_ADR;
      end
      icnt   <= '0;
      aadr_q <= '0;
      radr_q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        st_q[i] <= st_d;
        rd_q[i] <= a_ok ? bus.NADR : rd;
      end
      if (st[B_INIT]) icnt <= icnt + 1'b1;
      if (a_ok) aadr_q <= bus.NADR;
      if (r_ok) radr_q <= head;
    end
  end

  sca_adr_fifo #(
    .TMR (TMR)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (a_ok),
    .pop   (r_ok),
    .din   (bus.NADR),
    .head  (head),
    .count (cnt)
  );

  assign bus.ALLOC_ACK  = a_ok;
  assign bus.ALLOC_FAIL = in_chk && !a_ok;
  assign bus.ALLOC_ADR  = a_ok ? bus.NADR : aadr_q;
  assign bus.REL_ACK    = r_ok;
  assign bus.REL_ERR    = in_rel && empty;
  assign bus.REL_ADR    = r_ok ? head : radr_q;
  assign bus.BUSY       = !st[B_IDLE];
  assign bus.OCC_CNT    = cnt;
  assign bus.NBSEL      = st[B_SEL];
  assign bus.WRENA      = a_ok || r_ok;
  assign bus.SELA       = a_ok;
  assign bus.BADR       = a_ok ? bus.NADR :
                          r_ok ? head : '0;
  assign bus.RDADR      = rd;

endmodule
